// File: rtl/simd_dot_mac.sv
// Dot-product MAC: LANES byte pairs per beat, summed at 8x8/4x4/2x2 granularity and accumulated per batch.
// Three register stages (operand, dot product, accumulator/result) share one stall enable driven by result backpressure.
module simd_dot_mac #(
   parameter int LANES = 6,
   parameter int ACC_W = 48,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   a,
   input  logic [8*LANES-1:0]   b,
   input  logic                 a_sign,
   input  logic                 b_sign,
   input  logic [1:0]           mode,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     result,
   output logic [CNT_W-1:0]     beat_count,
   output logic                 overflow
);
   localparam int DOT_W = 19 + $clog2(LANES);

   // Sum of position-aligned field products within one byte lane.
   function automatic logic signed [17:0] lane_dot(
      input logic [7:0] x,
      input logic [7:0] y,
      input logic       sx,
      input logic       sy,
      input logic [1:0] m
   );
      logic signed [17:0] sum;
      logic signed [17:0] ex;
      logic signed [17:0] ey;
      sum = '0;
      ex  = '0;
      ey  = '0;
      case (m)
         2'b00: begin
            ex  = 18'($signed({sx & x[7], x}));
            ey  = 18'($signed({sy & y[7], y}));
            sum = ex * ey;
         end
         2'b01: begin
            for (int j = 0; j < 2; j++) begin
               ex  = 18'($signed({sx & x[4*j+3], x[4*j +: 4]}));
               ey  = 18'($signed({sy & y[4*j+3], y[4*j +: 4]}));
               sum = sum + ex * ey;
            end
         end
         2'b10: begin
            for (int j = 0; j < 4; j++) begin
               ex  = 18'($signed({sx & x[2*j+1], x[2*j +: 2]}));
               ey  = 18'($signed({sy & y[2*j+1], y[2*j +: 2]}));
               sum = sum + ex * ey;
            end
         end
         default: sum = '0;
      endcase
      return sum;
   endfunction

   logic                 w_en;
   logic                 r_s1_vld;
   logic [8*LANES-1:0]   r_s1_a;
   logic [8*LANES-1:0]   r_s1_b;
   logic                 r_s1_as;
   logic                 r_s1_bs;
   logic [1:0]           r_s1_mode;
   logic                 r_s1_last;
   logic                 r_s2_vld;
   logic [ACC_W-1:0]     r_s2_dot;
   logic                 r_s2_last;
   logic [ACC_W-1:0]     r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_ovf;
   logic                 r_open;
   logic                 r_out_vld;
   logic [ACC_W-1:0]     r_result;
   logic [CNT_W-1:0]     r_bcnt;
   logic                 r_ovf_out;

   logic signed [DOT_W-1:0] w_dot;
   logic [ACC_W-1:0]        w_dot_ext;
   logic [ACC_W-1:0]        w_acc_base;
   logic [ACC_W-1:0]        w_acc_sum;
   logic                    w_add_ovf;
   logic [CNT_W-1:0]        w_cnt_base;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    w_ovf_nxt;

   assign w_en       = !r_out_vld || out_ready;
   assign in_ready   = w_en;
   assign out_valid  = r_out_vld;
   assign result     = r_result;
   assign beat_count = r_bcnt;
   assign overflow   = r_ovf_out;

   always_comb begin
      w_dot = '0;
      for (int k = 0; k < LANES; k++) begin
         w_dot = w_dot + DOT_W'(lane_dot(r_s1_a[8*k +: 8], r_s1_b[8*k +: 8],
                                         r_s1_as, r_s1_bs, r_s1_mode));
      end
      w_dot_ext = ACC_W'(w_dot);
   end

   // A closed batch restarts from zero so the next beat opens a fresh sum.
   always_comb begin
      w_acc_base = r_open ? r_acc : '0;
      w_acc_sum  = w_acc_base + r_s2_dot;
      w_add_ovf  = (w_acc_base[ACC_W-1] == r_s2_dot[ACC_W-1]) &&
                   (w_acc_sum[ACC_W-1] != w_acc_base[ACC_W-1]);
      w_cnt_base = r_open ? r_cnt : '0;
      w_cnt_nxt  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
      w_ovf_nxt  = (r_open & r_ovf) | w_add_ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_a    <= '0;
         r_s1_b    <= '0;
         r_s1_as   <= 1'b0;
         r_s1_bs   <= 1'b0;
         r_s1_mode <= 2'b00;
         r_s1_last <= 1'b0;
         r_s2_vld  <= 1'b0;
         r_s2_dot  <= '0;
         r_s2_last <= 1'b0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_open    <= 1'b0;
         r_out_vld <= 1'b0;
         r_result  <= '0;
         r_bcnt    <= '0;
         r_ovf_out <= 1'b0;
      end else if (w_en) begin
         r_s1_vld  <= in_valid;
         r_s1_a    <= a;
         r_s1_b    <= b;
         r_s1_as   <= a_sign;
         r_s1_bs   <= b_sign;
         r_s1_mode <= mode;
         r_s1_last <= in_last;
         r_s2_vld  <= r_s1_vld;
         r_s2_dot  <= w_dot_ext;
         r_s2_last <= r_s1_last;
         // With en high a held result has been taken, so out_valid follows only new completions.
         r_out_vld <= r_s2_vld & r_s2_last;
         if (r_s2_vld) begin
            r_acc  <= w_acc_sum;
            r_cnt  <= w_cnt_nxt;
            r_ovf  <= w_ovf_nxt;
            r_open <= !r_s2_last;
            if (r_s2_last) begin
               r_result  <= w_acc_sum;
               r_bcnt    <= w_cnt_nxt;
               r_ovf_out <= w_ovf_nxt;
            end
         end
      end
   end
endmodule
